// File: rtl/bcd_score_digits_object.sv
// Saturating NUM_DIGITS-wide BCD score register with an on-screen digit-row readout; pixel outputs are registered (1-cycle latency) and there is no backpressure.
// Optional SCORE_BLINK_EN adds a startOfFrame input and hides the digits in a blink pattern for BLINK_FRAMES frames after each score add.
module bcd_score_digits_object #(
  parameter int         NUM_DIGITS         = 4,
  parameter int         DIGIT_WIDTH_X      = 16,
  parameter int         DIGIT_HEIGHT_Y     = 32,
  parameter int         topLeftX           = 560,
  parameter int         topLeftY           = 50,
  parameter logic [7:0] OBJECT_COLOR       = 8'h5b,
  parameter bit         LEADING_ZERO_BLANK = 1'b1,
  parameter int         BLINK_FRAMES       = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [10:0]             pixelX,
  input  logic [10:0]             pixelY,
  input  logic                    add_score,
  input  logic [3:0]              add_value,
  input  logic                    clear_score,
`ifdef SCORE_BLINK_EN
  input  logic                    startOfFrame,
`endif
  output logic [10:0]             offsetX,
  output logic [10:0]             offsetY,
  output logic                    drawingRequest,
  output logic [3:0]              index,
  output logic [7:0]              RGBout,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic                    overflow
);

  localparam int          LOG2W    = $clog2(DIGIT_WIDTH_X);
  localparam int          SPAN_X   = NUM_DIGITS * DIGIT_WIDTH_X;
  localparam logic [10:0] X_LO     = 11'(topLeftX);
  localparam logic [10:0] Y_LO     = 11'(topLeftY);
  localparam logic [11:0] SPAN_X12 = 12'(SPAN_X);
  localparam logic [11:0] SPAN_Y12 = 12'(DIGIT_HEIGHT_Y);
  localparam logic [10:0] OFS_MASK = 11'(DIGIT_WIDTH_X - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $fatal(1, "NUM_DIGITS must be 1..8");
  end
  if (DIGIT_WIDTH_X < 1 || (DIGIT_WIDTH_X & (DIGIT_WIDTH_X - 1)) != 0) begin : g_bad_width
    $fatal(1, "DIGIT_WIDTH_X must be a power of two");
  end
  if (topLeftX + SPAN_X > 2048 || topLeftY + DIGIT_HEIGHT_Y > 2048) begin : g_bad_bracket
    $fatal(1, "digit bracket extends past pixel 2047");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 65535) begin : g_bad_blink
    $fatal(1, "BLINK_FRAMES must be 1..65535");
  end

  // Score adder: nibble 0 of score_bcd is the least significant digit.
  logic [3:0]              add_v;
  logic [4:0]              carry;
  logic [4:0]              sum5;
  logic [4*NUM_DIGITS-1:0] sum_bcd;
  logic                    all_nines;
  logic                    sat;

  always_comb begin
    add_v     = (add_value > 4'd9) ? 4'd9 : add_value;
    carry     = {1'b0, add_v};
    sum5      = '0;
    sum_bcd   = score_bcd;
    all_nines = (score_bcd == {NUM_DIGITS{4'h9}});
    for (int n = 0; n < NUM_DIGITS; n++) begin
      sum5 = {1'b0, score_bcd[4*n +: 4]} + carry;
      if (sum5 > 5'd9) begin
        sum_bcd[4*n +: 4] = 4'(sum5 - 5'd10);
        carry             = 5'd1;
      end else begin
        sum_bcd[4*n +: 4] = sum5[3:0];
        carry             = 5'd0;
      end
    end
    sat = (carry != 5'd0) || all_nines;
  end

  always_ff @(posedge clk) begin
    if (reset || clear_score) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else if (add_score) begin
      if (sat) begin
        score_bcd <= {NUM_DIGITS{4'h9}};
        overflow  <= 1'b1;
      end else begin
        score_bcd <= sum_bcd;
      end
    end
  end

  logic blink_hide;
`ifdef SCORE_BLINK_EN
  logic [15:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear_score) begin
      blink_cnt <= '0;
    end else if (add_score) begin
      blink_cnt <= 16'(BLINK_FRAMES);
    end else if (startOfFrame && blink_cnt != 16'd0) begin
      blink_cnt <= blink_cnt - 16'd1;
    end
  end

  assign blink_hide = (blink_cnt != 16'd0) && blink_cnt[2];
`else
  assign blink_hide = 1'b0;
`endif

  // Pixel path: slot 0 (leftmost) maps to the most significant digit.
  logic [10:0]           rel_x;
  logic [10:0]           rel_y;
  logic [10:0]           slot;
  logic                  in_box;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic                  visible;

  always_comb begin
    rel_x  = pixelX - X_LO;
    rel_y  = pixelY - Y_LO;
    slot   = rel_x >> LOG2W;
    in_box = (pixelX >= X_LO) && ({1'b0, rel_x} < SPAN_X12) &&
             (pixelY >= Y_LO) && ({1'b0, rel_y} < SPAN_Y12);

    zero_run  = 1'b1;
    lead_zero = '0;
    for (int s = 0; s < NUM_DIGITS; s++) begin
      zero_run     = zero_run && (score_bcd[4*(NUM_DIGITS-1-s) +: 4] == 4'd0);
      lead_zero[s] = LEADING_ZERO_BLANK && zero_run && (s != NUM_DIGITS - 1);
    end

    cur_digit = 4'd0;
    cur_blank = 1'b1;
    for (int s = 0; s < NUM_DIGITS; s++) begin
      if (slot == 11'(s)) begin
        cur_digit = score_bcd[4*(NUM_DIGITS-1-s) +: 4];
        cur_blank = lead_zero[s];
      end
    end

    visible = in_box && !cur_blank && !blink_hide;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      offsetX        <= '0;
      offsetY        <= '0;
      drawingRequest <= 1'b0;
      index          <= '0;
      RGBout         <= 8'h00;
    end else if (visible) begin
      offsetX        <= rel_x & OFS_MASK;
      offsetY        <= rel_y;
      drawingRequest <= 1'b1;
      index          <= cur_digit;
      RGBout         <= OBJECT_COLOR;
    end else begin
      offsetX        <= '0;
      offsetY        <= '0;
      drawingRequest <= 1'b0;
      index          <= '0;
      RGBout         <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_bcd_score_digits_object.sv
// Bench for bcd_score_digits_object: integer-valued score model plus per-pixel expectation, checked every cycle.
module tb_bcd_score_digits_object;

  localparam int ND   = 4;
  localparam int W    = 16;
  localparam int H    = 32;
  localparam int X0   = 560;
  localparam int Y0   = 50;
  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        add_score = 1'b0;
  logic [3:0]  add_value = '0;
  logic        clear_score = 1'b0;
`ifdef SCORE_BLINK_EN
  logic        startOfFrame = 1'b0;
`endif
  logic [10:0] offsetX, offsetY;
  logic        drawingRequest;
  logic [3:0]  index;
  logic [7:0]  RGBout;
  logic [15:0] score_bcd;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  bcd_score_digits_object dut (
    .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
    .add_score(add_score), .add_value(add_value), .clear_score(clear_score),
`ifdef SCORE_BLINK_EN
    .startOfFrame(startOfFrame),
`endif
    .offsetX(offsetX), .offsetY(offsetY), .drawingRequest(drawingRequest),
    .index(index), .RGBout(RGBout), .score_bcd(score_bcd), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        dr;
    logic [10:0] ox;
    logic [10:0] oy;
    logic [3:0]  idx;
    logic [7:0]  rgb;
  } pix_t;

  function automatic int unsigned p10(input int k);
    int unsigned r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  function automatic int unsigned clampv(input logic [3:0] a);
    return (a > 4'd9) ? 9 : int'(a);
  endfunction

  // Expected pixel outputs from decimal arithmetic on the score value.
  function automatic pix_t pix_model(input int px, input int py, input int unsigned val, input bit hide);
    pix_t r;
    int slot;
    int unsigned dv;
    r = '0;
    r.rgb = 8'hFF;
    if (px >= X0 && px < X0 + ND*W && py >= Y0 && py < Y0 + H) begin
      slot = (px - X0) / W;
      dv   = p10(ND - 1 - slot);
      if (!(slot != ND - 1 && val < dv) && !hide) begin
        r.dr  = 1'b1;
        r.ox  = 11'((px - X0) % W);
        r.oy  = 11'(py - Y0);
        r.idx = 4'((val / dv) % 10);
        r.rgb = 8'h5b;
      end
    end
    return r;
  endfunction

  int unsigned m_val = 0;
  bit          m_ovf = 1'b0;
  bit          mv = 1'b0;
  pix_t        e_pix = '0;
  logic        m_hide;

`ifdef SCORE_BLINK_EN
  int m_bcnt = 0;
  always @(posedge clk) begin
    if (reset || clear_score) m_bcnt <= 0;
    else if (add_score) m_bcnt <= 32;
    else if (startOfFrame && m_bcnt > 0) m_bcnt <= m_bcnt - 1;
  end
  assign m_hide = (m_bcnt != 0) && ((m_bcnt % 8) >= 4);
`else
  assign m_hide = 1'b0;
`endif

  always @(posedge clk) begin
    mv <= 1'b1;
    if (reset) begin
      m_val <= 0;
      m_ovf <= 1'b0;
      e_pix <= '0;
    end else begin
      e_pix <= pix_model(int'(pixelX), int'(pixelY), m_val, m_hide);
      if (clear_score) begin
        m_val <= 0;
        m_ovf <= 1'b0;
      end else if (add_score) begin
        if (m_val + clampv(add_value) > MAXV || m_val == MAXV) begin
          m_val <= MAXV;
          m_ovf <= 1'b1;
        end else begin
          m_val <= m_val + clampv(add_value);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("score_bcd", score_bcd, to_bcd(m_val));
      chk("overflow", overflow, m_ovf);
      chk("drawingRequest", drawingRequest, e_pix.dr);
      chk("offsetX", offsetX, e_pix.ox);
      chk("offsetY", offsetY, e_pix.oy);
      chk("index", index, e_pix.idx);
      chk("RGBout", RGBout, e_pix.rgb);
    end
  end

  task automatic pulse_add(input logic [3:0] v);
    add_score = 1'b1;
    add_value = v;
    @(negedge clk);
    add_score = 1'b0;
  endtask

  task automatic load_score(input int target);
    int acc;
    int v;
    clear_score = 1'b1;
    @(negedge clk);
    clear_score = 1'b0;
    acc = 0;
    while (acc < target) begin
      v = (target - acc > 9) ? 9 : target - acc;
      pulse_add(4'(v));
      acc += v;
    end
  endtask

  task automatic show(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_score", score_bcd, 16'h0000);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_dr", drawingRequest, 1'b0);
    chk("rst_rgb", RGBout, 8'h00);
    reset = 1'b0;

    pulse_add(4'd7);
    pulse_add(4'd5);
    chk("add_7_5", score_bcd, 16'h0012);
    @(negedge clk);
    chk("add_7_5_ovf", overflow, 1'b0);
    pulse_add(4'd12);
    chk("add_12_as_9", score_bcd, 16'h0021);
    add_score = 1'b1;
    add_value = 4'd1;
    repeat (3) @(negedge clk);
    add_score = 1'b0;
    chk("held_add", score_bcd, 16'h0024);

    load_score(9995);
    chk("load_9995", score_bcd, 16'h9995);
    pulse_add(4'd9);
    chk("sat_score", score_bcd, 16'h9999);
    chk("sat_ovf", overflow, 1'b1);
    pulse_add(4'd1);
    chk("sat_sticky", overflow, 1'b1);
    clear_score = 1'b1;
    add_score   = 1'b1;
    add_value   = 4'd3;
    @(negedge clk);
    clear_score = 1'b0;
    add_score   = 1'b0;
    chk("clear_wins", score_bcd, 16'h0000);
    chk("clear_ovf", overflow, 1'b0);

    load_score(42);
    chk("load_42", score_bcd, 16'h0042);
    for (int x = 560; x <= 624; x++) begin
      show(x, 60);
      if (x == 560 || x == 591) chk("blank_lead", drawingRequest, 1'b0);
      if (x == 592) chk("slot2_idx", index, 4'd4);
      if (x == 592) chk("slot2_ox0", offsetX, 11'd0);
      if (x == 607) chk("slot2_ox15", offsetX, 11'd15);
      if (x == 608) chk("slot3_idx", index, 4'd2);
      if (x == 624) chk("right_edge_rgb", RGBout, 8'hFF);
    end

    load_score(1234);
    show(575, 81);
    chk("corner_dr", drawingRequest, 1'b1);
    chk("corner_ox", offsetX, 11'd15);
    chk("corner_oy", offsetY, 11'd31);
    chk("corner_idx", index, 4'd1);
    show(576, 82);
    chk("below_dr", drawingRequest, 1'b0);
    show(623, 50);
    chk("last_idx", index, 4'd4);
    show(559, 60);
    show(560, 49);
    chk("above_dr", drawingRequest, 1'b0);

    load_score(0);
    show(610, 60);
    chk("lsd_zero_dr", drawingRequest, 1'b1);
    show(600, 60);
    chk("zero_slot2_dr", drawingRequest, 1'b0);

    pulse_add(4'd8);
    show(612, 70);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rgb", RGBout, 8'h00);
    chk("midrst_score", score_bcd, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_dr", drawingRequest, 1'b1);

`ifdef SCORE_BLINK_EN
    pulse_add(4'd1);
    show(620, 60);
    for (int f = 1; f <= 34; f++) begin
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      repeat (2) @(negedge clk);
      if (f == 1) chk("blink_31", drawingRequest, 1'b0);
      if (f == 8) chk("blink_24", drawingRequest, 1'b1);
      if (f == 34) chk("blink_done", drawingRequest, 1'b1);
    end
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_score_digits_object.md
Name: bcd_score_digits_object

Overview:
- N-digit on-screen score readout for the VGA layer.
- Holds a saturating BCD score register that is updated by add/clear pulses from game logic.
- Per pixel, emits the bracket hit, the in-digit offsets and the BCD digit value to the digit-bitmap ROM/mux.
- Successor to the single-digit square object: parametrised digit count, internal score state, leading-zero blanking, overflow flag.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8); digit 0 = leftmost = most significant.
- DIGIT_WIDTH_X, 16, pixel width of one digit cell; must be a power of two.
- DIGIT_HEIGHT_Y, 32, pixel height of a digit cell.
- topLeftX, 560, screen X of the leftmost digit cell.
- topLeftY, 50, screen Y of the digit row.
- OBJECT_COLOR, 8'h5b, RGBout value when drawing.
- LEADING_ZERO_BLANK, 1, 1 = suppress leading zeros; 0 = show every digit.
- BLINK_FRAMES, 32, blink duration in frames (used only with the optional feature).

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high reset.
- pixelX  in  11  current VGA pixel X.
- pixelY  in  11  current VGA pixel Y.
- add_score  in  1  one-cycle pulse: add add_value to the score.
- add_value  in  4  BCD amount 0..9; values 10..15 are treated as 9.
- clear_score  in  1  one-cycle pulse: score := 0, overflow := 0.
- offsetX  out  11  X offset inside the current digit cell (0..DIGIT_WIDTH_X-1).
- offsetY  out  11  Y offset inside the cell.
- drawingRequest  out  1  pixel lies in a visible digit cell.
- index  out  4  BCD value of the digit under the pixel.
- RGBout  out  8  OBJECT_COLOR or 8'hFF (transparent).
- score_bcd  out  4*NUM_DIGITS  current score; digit 0 occupies the top nibble.
- overflow  out  1  sticky saturation flag.

Behaviour:
- Reset (clk edge with reset=1) clears all registers:
  - score_bcd=0, overflow=0;
  - offsetX=0, offsetY=0, drawingRequest=0, index=0, RGBout=8'h00.
- Score update takes effect on the clk edge of the pulse; score_bcd is valid on the next cycle.
- Add = ripple BCD add of add_value into the least significant digit, carry propagated upward. Each digit stays 0..9.
- Saturation: if the carry leaves digit 0, the score becomes all 9s and overflow := 1.
  - overflow is sticky until clear_score or reset.
  - Adding to an all-9s score leaves it unchanged and sets overflow=1.
- Simultaneous add_score and clear_score: clear wins and the add is dropped.
- add_score held high adds once per cycle; no edge detection.
- Pixel path has 1-cycle registered latency: outputs at cycle n+1 reflect pixelX/pixelY at cycle n, using the score_bcd value at cycle n.
- Bracket test: topLeftX <= pixelX < topLeftX + NUM_DIGITS*DIGIT_WIDTH_X, and topLeftY <= pixelY < topLeftY + DIGIT_HEIGHT_Y.
- Inside the bracket:
  - slot = (pixelX - topLeftX) >> log2(DIGIT_WIDTH_X);
  - offsetX = (pixelX - topLeftX) & (DIGIT_WIDTH_X-1);
  - offsetY = pixelY - topLeftY;
  - index = digit[slot].
- Leading-zero blanking (LEADING_ZERO_BLANK=1): slot s is blank if every digit 0..s is zero and s != NUM_DIGITS-1. The least significant digit is always drawn.
- Visible slot: drawingRequest=1, RGBout=OBJECT_COLOR.
- Blank slot or outside the bracket: drawingRequest=0, RGBout=8'hFF, offsetX=0, offsetY=0, index=0.
- All comparisons are unsigned 11-bit. A bracket extending past pixel 2047 is illegal; this is checked by an elaboration assertion.
- Reset asserted mid-frame forces the reset values on the next edge; the pixel path resumes on the first cycle after reset deasserts.

Optional Feature:
- Macro SCORE_BLINK_EN.
- When defined:
  - Extra input port startOfFrame (1 bit), a one-cycle pulse per frame.
  - Any accepted add_score loads a frame counter with BLINK_FRAMES. The counter decrements on each startOfFrame and stops at 0.
  - While the counter is nonzero and counter bit 2 = 1, every drawn pixel is forced transparent (drawingRequest=0, RGBout=8'hFF).
  - clear_score and reset zero the counter.
- When not defined: no startOfFrame port, no counter; the display is never blanked by updates.

Test Plan:
- Reset held 2 cycles, then released -> score_bcd=16'h0000, overflow=0, drawingRequest=0, RGBout=8'h00 before the first pixel.
- Pulse add_value=7, then add_value=5 -> score_bcd=16'h0012 two cycles after the second pulse; no overflow.
- Load 16'h9995 with add pulses, then add 9 -> score_bcd=16'h9999, overflow=1. clear_score together with add_score=3 -> 16'h0000, overflow=0.
- Score 16'h0042, pixel sweep of row Y=60 over X=560..623 -> drawingRequest=0 for X=560..591 (blanked). For X=592..607: index=4, offsetX 0..15. For X=608..623: index=2. X=624 -> 0, RGBout=FF.
- Pixel (575,81) at cycle n -> at cycle n+1 offsetX=15, offsetY=31. Pixel (576,82) -> drawingRequest=0 (Y out of bracket).
- SCORE_BLINK_EN defined: add 1, then 8 startOfFrame pulses -> counter 32→24. drawingRequest low for counter values 31..28 and 23..20 (bit 2 = 1); after 32 frames the digit is steadily visible.
